// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC FIFO data demultiplexer: state encoding,
// default word geometry and the ID-field width helper.
package tdc_pkg;

    localparam int unsigned TDC_COUNT_DEF      = 8;
    localparam int unsigned TDC_DATA_WIDTH_DEF = 40;
    localparam int unsigned ID_LSB_DEF         = 36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } demux_state_e;

    // ID field is at least one bit wide even for a single downstream FIFO.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdc_id_decode.sv
// TDC-ID decoder: binary id to one-hot select plus an in-range flag.
module tdc_id_decode #(
    parameter int unsigned TDC_COUNT = 8,
    parameter int unsigned ID_W      = 3
) (
    input  logic [ID_W-1:0]      i_id,
    output logic [TDC_COUNT-1:0] o_onehot,
    output logic                 o_in_range
);

    always_comb begin
        o_onehot   = '0;
        o_in_range = (32'(i_id) < TDC_COUNT);
        for (int unsigned k = 0; k < TDC_COUNT; k++) begin
            o_onehot[k] = (32'(i_id) == k);
        end
    end

endmodule

// File: rtl/tdc_fifo_data_demux.sv
// Routes words from one upstream FWFT FIFO to per-TDC FIFOs by the ID field,
// dropping words for unlocked/out-of-range targets or after a bounded stall.
// Optional drop counter enabled by defining TDC_DEMUX_DROP_COUNT_EN.
module tdc_fifo_data_demux
    import tdc_pkg::*;
#(
    parameter int unsigned TDC_COUNT      = TDC_COUNT_DEF,
    parameter int unsigned TDC_DATA_WIDTH = TDC_DATA_WIDTH_DEF,
    parameter int unsigned ID_LSB         = ID_LSB_DEF,
    parameter int unsigned STALL_LIMIT    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      src_empty,
    input  logic [TDC_DATA_WIDTH-1:0] src_data,
    output logic                      src_read,
    input  logic [TDC_COUNT-1:0]      locked,
    input  logic [TDC_COUNT-1:0]      dst_full,
    output logic [TDC_COUNT-1:0]      dst_write,
    output logic [TDC_DATA_WIDTH-1:0] dst_data,
    output logic                      drop_pulse
`ifdef TDC_DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam int unsigned ID_W    = id_width(TDC_COUNT);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    demux_state_e              r_state;
    demux_state_e              w_state_nxt;
    logic [TDC_DATA_WIDTH-1:0] r_hold;
    logic [STALL_W-1:0]        r_stall;
    logic                      r_ready;

    logic [ID_W-1:0]      w_id;
    logic [TDC_COUNT-1:0] w_onehot;
    logic                 w_in_range;
    logic                 w_target_ok;
    logic                 w_target_full;
    logic                 w_can_read;
    logic                 w_capture;
    logic                 w_clear;
    logic                 w_stall_inc;

    assign w_id          = r_hold[ID_LSB +: ID_W];
    assign w_target_ok   = w_in_range && (|(w_onehot & locked));
    assign w_target_full = |(w_onehot & dst_full);
    assign w_can_read    = r_ready && !src_empty;
    assign dst_data      = r_hold;

    tdc_id_decode #(
        .TDC_COUNT (TDC_COUNT),
        .ID_W      (ID_W)
    ) u_id_decode (
        .i_id       (w_id),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    // Lock and full are re-evaluated every HOLD cycle so a link dropping lock discards the word.
    always_comb begin
        w_state_nxt = r_state;
        src_read    = 1'b0;
        dst_write   = '0;
        drop_pulse  = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_can_read) begin
                    src_read    = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_target_ok) begin
                    w_state_nxt = ST_DROP;
                end else if (!w_target_full) begin
                    dst_write = w_onehot;
                    if (w_can_read) begin
                        src_read  = 1'b1;
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_stall_inc = 1'b1;
                    if (32'(r_stall) + 32'd1 >= STALL_LIMIT) begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                drop_pulse = 1'b1;
                w_clear    = 1'b1;
                if (w_can_read) begin
                    src_read    = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_stall <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= 1'b1;
            if (w_capture) begin
                r_hold  <= src_data;
                r_stall <= '0;
            end else begin
                if (w_clear) begin
                    r_hold <= '0;
                end
                if (w_stall_inc) begin
                    r_stall <= r_stall + STALL_W'(1);
                end
            end
        end
    end

`ifdef TDC_DEMUX_DROP_COUNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (drop_pulse && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tdc_fifo_data_demux.sv
// Randomized and directed bench for tdc_fifo_data_demux against a word-level
// reference model; checks drop_count too when TDC_DEMUX_DROP_COUNT_EN is defined.
module tb_tdc_fifo_data_demux;

    localparam int unsigned TC  = 6;
    localparam int unsigned DW  = 40;
    localparam int unsigned IDL = 36;
    localparam int unsigned IDW = 3;
    localparam int unsigned SL  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          src_empty;
    logic [DW-1:0] src_data;
    logic          src_read;
    logic [TC-1:0] locked;
    logic [TC-1:0] dst_full;
    logic [TC-1:0] dst_write;
    logic [DW-1:0] dst_data;
    logic          drop_pulse;
`ifdef TDC_DEMUX_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    always #5 clk = ~clk;

    tdc_fifo_data_demux #(
        .TDC_COUNT      (TC),
        .TDC_DATA_WIDTH (DW),
        .ID_LSB         (IDL),
        .STALL_LIMIT    (SL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_empty  (src_empty),
        .src_data   (src_data),
        .src_read   (src_read),
        .locked     (locked),
        .dst_full   (dst_full),
        .dst_write  (dst_write),
        .dst_data   (dst_data),
        .drop_pulse (drop_pulse)
`ifdef TDC_DEMUX_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Upstream FIFO contents and environment knobs
    logic [DW-1:0] src_q[$];
    bit            g_bubble;
    logic [TC-1:0] g_locked;
    logic [TC-1:0] g_full;

    // Word-level reference model: is a word held, is it condemned, how long has it waited
    bit            m_busy;
    bit            m_doomed;
    logic [DW-1:0] m_word;
    int            m_waited;
    bit            m_ready;
    int            m_dcnt;

    // Observations for directed scenario checks
    int            cyc;
    int            obs_writes;
    int            obs_drops;
    int            first_rd_cyc;
    int            first_wr_cyc;
    int            last_wr_cyc;
    logic [TC-1:0] last_wr_mask;
    logic [DW-1:0] last_wr_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int unsigned id);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[IDL +: IDW] = IDW'(id);
        return r[DW-1:0];
    endfunction

    task automatic clear_obs();
        obs_writes   = 0;
        obs_drops    = 0;
        first_rd_cyc = -1;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        last_wr_mask = '0;
        last_wr_data = '0;
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_doomed = 0;
        m_word   = '0;
        m_waited = 0;
        m_dcnt   = 0;
    endtask

    // One clock: drive after negedge, compare just after, advance the model
    task automatic run_cycle();
        logic          exp_read;
        logic          exp_pulse;
        logic [TC-1:0] exp_wr;
        logic [DW-1:0] sh;
        int unsigned   id;
        bit            ok;
        @(negedge clk);
        cyc++;
        src_empty = (src_q.size() == 0) || g_bubble;
        src_data  = (src_q.size() != 0) ? src_q[0] : '0;
        locked    = g_locked;
        dst_full  = g_full;
        #1;
        sh        = m_word >> IDL;
        id        = 32'(sh[IDW-1:0]);
        ok        = (id < TC) ? g_locked[id] : 1'b0;
        exp_read  = 1'b0;
        exp_pulse = 1'b0;
        exp_wr    = '0;
        if (m_doomed) begin
            exp_pulse = 1'b1;
            exp_read  = m_ready && !src_empty;
        end else if (m_busy) begin
            if (ok && !g_full[id]) begin
                exp_wr[id] = 1'b1;
                exp_read   = m_ready && !src_empty;
            end
        end else begin
            exp_read = m_ready && !src_empty;
        end

        check_eq("src_read", 64'(src_read), 64'(exp_read));
        check_eq("dst_write", 64'(dst_write), 64'(exp_wr));
        check_eq("dst_data", 64'(dst_data), 64'(m_word));
        check_eq("drop_pulse", 64'(drop_pulse), 64'(exp_pulse));
`ifdef TDC_DEMUX_DROP_COUNT_EN
        check_eq("drop_count", 64'(drop_count), 64'(m_dcnt));
`endif

        if (src_read && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (dst_write != '0) begin
            obs_writes++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc  = cyc;
            last_wr_mask = dst_write;
            last_wr_data = dst_data;
        end
        if (drop_pulse) obs_drops++;

        if (m_doomed) begin
            if (m_dcnt < 65535) m_dcnt++;
            m_doomed = 0;
            m_busy   = 0;
            m_word   = '0;
        end else if (m_busy) begin
            if (!ok) begin
                m_doomed = 1;
            end else if (!g_full[id]) begin
                m_busy = 0;
            end else begin
                m_waited++;
                if (m_waited >= int'(SL)) m_doomed = 1;
            end
        end
        if (exp_read) begin
            m_word   = src_q.pop_front();
            m_busy   = 1;
            m_doomed = 0;
            m_waited = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Asynchronous reset pulse; outputs must be quiet throughout and no read before a clean edge
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        src_empty = 1'b0;
        src_data  = mk_word(1);
        #1;
        check_eq({tag, "_rd"}, 64'(src_read), 64'd0);
        check_eq({tag, "_wr"}, 64'(dst_write), 64'd0);
        check_eq({tag, "_drop"}, 64'(drop_pulse), 64'd0);
        check_eq({tag, "_data"}, 64'(dst_data), 64'd0);
`ifdef TDC_DEMUX_DROP_COUNT_EN
        check_eq({tag, "_dcnt"}, 64'(drop_count), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check_eq({tag, "_hold_rd"}, 64'(src_read), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq({tag, "_first_rd"}, 64'(src_read), 64'd0);
        model_reset();
        m_ready = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        src_empty = 1'b1;
        src_data  = '0;
        locked    = '0;
        dst_full  = '0;
        g_bubble  = 0;
        g_locked  = '1;
        g_full    = '0;
        m_ready   = 0;
        cyc       = 0;
        model_reset();
        clear_obs();

        apply_reset("reset");

        // Single word to id 3
        clear_obs();
        src_q.push_back(mk_word(3));
        run(4);
        check_eq("s1_writes", 64'(obs_writes), 64'd1);
        check_eq("s1_mask", 64'(last_wr_mask), 64'h08);
        check_eq("s1_latency", 64'(first_wr_cyc - first_rd_cyc), 64'd1);
        check_eq("s1_drops", 64'(obs_drops), 64'd0);

        // Back-to-back words to every target, no bubbles
        clear_obs();
        for (int k = 0; k < int'(TC); k++) src_q.push_back(mk_word(k));
        run(10);
        check_eq("s2_writes", 64'(obs_writes), 64'(TC));
        check_eq("s2_span", 64'(last_wr_cyc - first_wr_cyc), 64'(TC - 1));
        check_eq("s2_last_mask", 64'(last_wr_mask), 64'h20);

        // Target full for ten cycles, then released
        clear_obs();
        g_full[2] = 1'b1;
        src_q.push_back(mk_word(2));
        run(11);
        g_full = '0;
        run(3);
        check_eq("s3_writes", 64'(obs_writes), 64'd1);
        check_eq("s3_wait", 64'(first_wr_cyc - first_rd_cyc), 64'd11);
        check_eq("s3_drops", 64'(obs_drops), 64'd0);

        // Target stuck full: dropped after the stall limit, next word still flows
        clear_obs();
        g_full[5] = 1'b1;
        src_q.push_back(mk_word(5));
        run(int'(SL) + 4);
        check_eq("s4_drops", 64'(obs_drops), 64'd1);
        check_eq("s4_nowrite", 64'(obs_writes), 64'd0);
        src_q.push_back(mk_word(1));
        run(3);
        check_eq("s4_next_write", 64'(obs_writes), 64'd1);
        check_eq("s4_next_mask", 64'(last_wr_mask), 64'h02);
        g_full = '0;

        // Out-of-range id, then an unlocked target
        clear_obs();
        g_locked[1] = 1'b0;
        src_q.push_back(mk_word(7));
        src_q.push_back(mk_word(1));
        run(8);
        check_eq("s5_drops", 64'(obs_drops), 64'd2);
        check_eq("s5_writes", 64'(obs_writes), 64'd0);
        g_locked = '1;

        // Reset while a word is held
        clear_obs();
        g_full[0] = 1'b1;
        src_q.push_back(mk_word(0));
        src_q.push_back(mk_word(4));
        run(3);
        apply_reset("midhold");
        g_full = '0;
        run(4);
        check_eq("s6_writes", 64'(obs_writes), 64'd1);
        check_eq("s6_mask", 64'(last_wr_mask), 64'h10);
        check_eq("s6_drops", 64'(obs_drops), 64'd0);

        // Randomized traffic: sticky full patterns, rare unlocks, bubbles, one reset
        for (int c = 0; c < 4000; c++) begin
            if (src_q.size() < 4) src_q.push_back(mk_word($urandom_range(0, 7)));
            g_bubble = ($urandom_range(0, 4) == 0);
            if ((c % 16) == 0) g_full = TC'($urandom()) & TC'($urandom());
            if ($urandom_range(0, 31) == 0) g_locked = ~(TC'(1) << $urandom_range(0, TC - 1));
            else if ($urandom_range(0, 7) == 0) g_locked = '1;
            if (c == 2000) apply_reset("rand_rst");
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
